// File: rtl/eater_pkg.sv
// Shared definitions for the 8-bit bus CPU and its program RAM.
// Holds the default word/address widths and the RAM sequencer state type.
package eater_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned ADDR_W_DEF = 4;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_RUN   = 2'd1,
    ST_PROG  = 2'd2
  } ram_state_e;

endpackage

// File: rtl/prog_ram_if.sv
// CPU bus strobes and loader handshake for prog_ram.
// master: CPU/loader side (drives bus_i, mi, ri, ro, prog_*), sees busy/prog_ready/prog_ptr.
// slave : RAM side.
interface prog_ram_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
);
  logic [DATA_W-1:0] bus_i;
  logic              mi;
  logic              ri;
  logic              ro;
  logic              busy;
  logic              prog_en;
  logic              prog_auto;
  logic [ADDR_W-1:0] prog_addr;
  logic [DATA_W-1:0] prog_data;
  logic              prog_valid;
  logic              prog_ready;
  logic [ADDR_W-1:0] prog_ptr;

  modport master (
    output bus_i, mi, ri, ro, prog_en, prog_auto, prog_addr, prog_data, prog_valid,
    input  busy, prog_ready, prog_ptr
  );

  modport slave (
    input  bus_i, mi, ri, ro, prog_en, prog_auto, prog_addr, prog_data, prog_valid,
    output busy, prog_ready, prog_ptr
  );
endinterface

// File: rtl/ram_array.sv
// DEPTH x DATA_W storage: one synchronous write port, one asynchronous read port.
// Ports: clk, we/waddr/wdata (write on rising edge), raddr -> rdata (combinational).
module ram_array #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Contents are defined by the clear sequencer, so no reset here.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/prog_ram.sv
// Program RAM for the 8-bit bus CPU: MAR, reset-time zero fill and a loader
// programming mode that holds the CPU off while memory is filled.
// Ports: clk, rst (sync, active-high), bus (prog_ram_if.slave: CPU strobes and
// loader handshake), data_o (memory[MAR] while ro in RUN, else high-impedance).
module prog_ram
  import eater_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  prog_ram_if.slave         bus,
  output logic [DATA_W-1:0] data_o
);
  localparam int unsigned DEPTH = 1 << ADDR_W;

  ram_state_e        state_q, state_d;
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              we;
  logic              mem_we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;

  // State, MAR, clear counter and loader pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      mar_q   <= '0;
      cnt_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      mar_q   <= mar_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next state plus write-port mux (clear / loader / CPU).
  always_comb begin
    state_d = state_q;
    mar_d   = mar_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    we      = 1'b0;
    waddr   = mar_q;
    wdata   = bus.bus_i;
    case (state_q)
      ST_CLEAR: begin
        we    = 1'b1;
        waddr = cnt_q;
        wdata = '0;
        cnt_d = cnt_q + 1'b1;
        ptr_d = '0;
        if (cnt_q == ADDR_W'(DEPTH - 1)) state_d = bus.prog_en ? ST_PROG : ST_RUN;
      end
      ST_RUN: begin
        // Write addresses the MAR value from before this edge.
        we = bus.ri;
        if (bus.mi) mar_d = bus.bus_i[ADDR_W-1:0];
        if (bus.prog_en) begin
          state_d = ST_PROG;
          ptr_d   = '0;
        end
      end
      ST_PROG: begin
        // Ready is implied by the state, so valid alone marks a transfer.
        we    = bus.prog_valid;
        waddr = bus.prog_auto ? ptr_q : bus.prog_addr;
        wdata = bus.prog_data;
        if (bus.prog_valid && bus.prog_auto) ptr_d = ptr_q + 1'b1;
        if (!bus.prog_en) state_d = ST_RUN;
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  // A reset cycle must not commit a pending write.
  assign mem_we = we && !rst;

  ram_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (mem_we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (mar_q),
    .rdata (rdata)
  );

  assign bus.busy       = (state_q != ST_RUN);
  assign bus.prog_ready = (state_q == ST_PROG);
  assign bus.prog_ptr   = ptr_q;
  // Pre-write contents are visible when ri and ro coincide.
  assign data_o = (state_q == ST_RUN && bus.ro) ? rdata : {DATA_W{1'bz}};
endmodule
